// File: rtl/stepper_sequencer_pkg.sv
// Shared types and constants for the stepper sequencer: coil phase table, FSM states.
package stepper_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [2:0] RESET_IDX = 3'd1;

  // Full-step patterns sit at odd indices, half-step intermediates at even ones.
  localparam logic [3:0] PHASE_TABLE [0:7] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110,
    4'b0100, 4'b1100, 4'b1000, 4'b1001
  };

  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    return PHASE_TABLE[idx];
  endfunction

endpackage

// File: rtl/stepper_sequencer_if.sv
// Move-command handshake between host control logic and the stepper sequencer.
interface stepper_sequencer_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 20
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic             cmd_half;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_sequencer_step_timer.sv
// Step-rate down-counter: tick marks the cycle whose closing edge applies a step.
module step_timer #(
  parameter int unsigned DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;

  // Loaded with P on the accept edge, so the count reaches 1 just before edge k+P.
  assign tick = run && (cnt_q == DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (load) begin
      cnt_d = period;
      per_d = period;
    end else if (!run) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = per_q;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/stepper_sequencer.sv
// Command-driven 4-coil unipolar stepper sequencer with full/half-step modes and position tracking.
module stepper_sequencer
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 20,
  parameter int unsigned POS_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  stepper_sequencer_if.slave      cmd,
  input  logic                    abort,
  output logic [3:0]              phase,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [CNT_W-1:0]        steps_left,
  output logic signed [POS_W-1:0] pos
);

  state_e                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [3:0]              phase_q, phase_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0]        left_q, left_d;
  logic                    dir_q, dir_d;
  logic                    half_q, half_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;

  logic             accept;
  logic             load;
  logic             tick;
  logic [DIV_W-1:0] period_eff;
  logic [1:0]       step_mag;
  logic [2:0]       idx_step;
  logic [POS_W-1:0] pos_step;

  assign cmd.cmd_ready = (state_q == IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign period_eff    = (cmd.cmd_period == '0) ? DIV_W'(1) : cmd.cmd_period;

  // Full mode from an even (half-step) index realigns with a single index move.
  assign step_mag = (half_q || !idx_q[0]) ? 2'd1 : 2'd2;
  assign idx_step = dir_q ? (idx_q + {1'b0, step_mag}) : (idx_q - {1'b0, step_mag});
  assign pos_step = dir_q ? (pos_q + POS_W'(step_mag)) : (pos_q - POS_W'(step_mag));

  step_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (state_q == RUN),
    .load  (load),
    .period(period_eff),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    left_d    = left_q;
    dir_d     = dir_q;
    half_d    = half_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd.cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            dir_d   = cmd.cmd_dir;
            half_d  = cmd.cmd_half;
            left_d  = cmd.cmd_steps;
            load    = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (tick) begin
          idx_d  = idx_step;
          pos_d  = pos_step;
          left_d = left_q - CNT_W'(1);
          if (left_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    phase_d = phase_of(idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= RESET_IDX;
      phase_q   <= phase_of(RESET_IDX);
      pos_q     <= '0;
      left_q    <= '0;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      left_q    <= left_d;
      dir_q     <= dir_d;
      half_q    <= half_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign phase      = phase_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = left_q;
  assign pos        = pos_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed bench for stepper_sequencer: vector table of whole moves plus timing/abort/reset sequences.
module tb_stepper_sequencer;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DIV_W = 20;
  localparam int unsigned POS_W = 24;

  logic                    clk;
  logic                    rst;
  logic                    abort;
  logic [3:0]              phase;
  logic                    busy;
  logic                    done;
  logic                    aborted;
  logic [CNT_W-1:0]        steps_left;
  logic signed [POS_W-1:0] pos;

  int total;
  int bad;

  stepper_sequencer_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

  stepper_sequencer #(
    .CNT_W(CNT_W),
    .DIV_W(DIV_W),
    .POS_W(POS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (bus.slave),
    .abort     (abort),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .steps_left(steps_left),
    .pos       (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dir;
    logic       half;
    int         steps;
    int         period;
    logic [3:0] ph;
    int         pos;
    int         cyc;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pos_now();
    return int'($signed(pos));
  endfunction

  // Returns just after the accept edge (#1 past it).
  task automatic issue(input logic dir, input logic half, input int steps, input int period);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_dir    = dir;
    bus.cmd_half   = half;
    bus.cmd_steps  = CNT_W'(steps);
    bus.cmd_period = DIV_W'(period);
    bus.cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output int busy_bad);
    n = 0;
    busy_bad = 0;
    while (!done && n < limit) begin
      if (!busy) busy_bad++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int bb;
    logic [3:0] exp_ph;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    abort = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_dir    = 1'b0;
    bus.cmd_half   = 1'b0;
    bus.cmd_steps  = '0;
    bus.cmd_period = '0;

    //            dir   half  steps per  phase    pos cyc
    vecs[0] = '{1'b1, 1'b0, 4, 3, 4'b0011,  8, 12};
    vecs[1] = '{1'b0, 1'b1, 3, 1, 4'b1000,  5,  3};
    vecs[2] = '{1'b1, 1'b1, 4, 1, 4'b0010,  9,  4};
    vecs[3] = '{1'b1, 1'b0, 2, 2, 4'b1100, 12,  4};
    vecs[4] = '{1'b0, 1'b0, 0, 5, 4'b1100, 12,  0};
    vecs[5] = '{1'b0, 1'b0, 2, 0, 4'b0011,  8,  2};
    vecs[6] = '{1'b0, 1'b0, 3, 1, 4'b0110,  2,  3};
    vecs[7] = '{1'b0, 1'b0, 2, 1, 4'b1001, -2,  2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_phase", {28'd0, phase}, 32'h3);
    check("rst_pos", pos_now(), 32'd0);
    check("rst_left", {16'd0, steps_left}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {30'd0, done, aborted}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Whole moves, state carried from one vector to the next
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].dir, vecs[i].half, vecs[i].steps, vecs[i].period);
      wait_done(200, n, bb);
      check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
      check($sformatf("v%0d_busy_during", i), bb, 32'd0);
      check($sformatf("v%0d_phase", i), {28'd0, phase}, {28'd0, vecs[i].ph});
      check($sformatf("v%0d_pos", i), pos_now(), vecs[i].pos);
      check($sformatf("v%0d_left", i), {16'd0, steps_left}, 32'd0);
      check($sformatf("v%0d_end_flags", i), {29'd0, aborted, busy, bus.cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Abort coinciding with step 3: idx 7 -> 1 -> 3, then abort
    issue(1'b1, 1'b0, 10, 4);
    repeat (11) @(posedge clk);
    #1;
    check("ab_pre_left", {16'd0, steps_left}, 32'd8);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("ab_flags", {29'd0, done, aborted, bus.cmd_ready}, 32'h7);
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_left", {16'd0, steps_left}, 32'd8);
    check("ab_phase", {28'd0, phase}, 32'h6);
    check("ab_pos", pos_now(), 32'd2);
    @(posedge clk);
    #1;
    check("ab_pulse", {30'd0, done, aborted}, 32'd0);

    // Abort with a command in IDLE: command wins
    @(negedge clk);
    abort = 1'b1;
    issue(1'b1, 1'b1, 1, 1);
    abort = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 32'd1);
    wait_done(20, n, bb);
    check("idle_abort_cyc", n, 32'd1);
    check("idle_abort_aborted", {31'd0, aborted}, 32'd0);
    check("idle_abort_phase", {28'd0, phase}, 32'h4);
    check("idle_abort_pos", pos_now(), 32'd3);

    // Reset mid-move
    issue(1'b1, 1'b0, 5, 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_phase", {28'd0, phase}, 32'h3);
    check("mid_rst_pos", pos_now(), 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_left", {16'd0, steps_left}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_no_done", {31'd0, done}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Edge-accurate step timing from reset position
    issue(1'b1, 1'b0, 4, 3);
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      #1;
      if (j < 3) exp_ph = 4'b0011;
      else if (j < 6) exp_ph = 4'b0110;
      else if (j < 9) exp_ph = 4'b1100;
      else if (j < 12) exp_ph = 4'b1001;
      else exp_ph = 4'b0011;
      check($sformatf("t1_phase_e%0d", j), {28'd0, phase}, {28'd0, exp_ph});
      check($sformatf("t1_done_e%0d", j), {31'd0, done}, {31'd0, (j == 12)});
    end
    check("t1_pos", pos_now(), 32'd8);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // Half-step reverse, one step per clock
    issue(1'b0, 1'b1, 3, 1);
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk);
      #1;
      case (j)
        1:       exp_ph = 4'b0001;
        2:       exp_ph = 4'b1001;
        default: exp_ph = 4'b1000;
      endcase
      check($sformatf("t2_phase_e%0d", j), {28'd0, phase}, {28'd0, exp_ph});
    end
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_pos", pos_now(), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
